// File: rtl/gf2lm_pkg.sv
// Shared types and helpers for the GF(2) linear-map block.
// No logic of its own; constants and pure functions only.
// Types are sized for the default word width; the top is parametrised separately.
package gf2lm_pkg;

    localparam int GF2LM_N = 32;

    typedef logic [GF2LM_N-1:0] row_t;
    typedef row_t [GF2LM_N-1:0] mat_t;
    typedef logic               bank_t;

    // One-hot row for identity position idx, wide enough for the largest legal N.
    function automatic logic [63:0] ident_row(input int idx);
        return 64'd1 << idx;
    endfunction

    // Identity matrix at the default width.
    function automatic mat_t identity_mat();
        mat_t m;
        for (int i = 0; i < GF2LM_N; i++) begin
            m[i] = row_t'(ident_row(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/gf2_matvec.sv
// Combinational N x N GF(2) matrix-vector product: y[i] = parity(a & row i).
// Latency 0 (pure combinational).
// No handshake; the caller registers the result.
module gf2_matvec
    import gf2lm_pkg::*;
#(
    parameter int N = GF2LM_N
) (
    input  logic [N-1:0][N-1:0] mat,
    input  logic [N-1:0]        a,
    output logic [N-1:0]        y
);

    // Each output bit is the XOR-reduction of the operand masked by its row.
    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            y[i] = ^(a & mat[i]);
        end
    end

endmodule

// File: rtl/gf2_linmap_dbuf.sv
// Double-buffered GF(2) linear map y = M*a (optional affine term when GF2LM_AFFINE_EN is defined).
// Latency 1 cycle from acceptance to out_valid; full throughput with out_ready high.
// Single output register: in_ready = !out_valid | out_ready, result held while stalled.
module gf2_linmap_dbuf
    import gf2lm_pkg::*;
#(
    parameter int N = GF2LM_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_data,
    input  logic                   cfg_valid,
    input  logic [N-1:0]           cfg_data,
    input  logic                   cfg_commit,
`ifdef GF2LM_AFFINE_EN
    input  logic                   cfg_cvalid,
    input  logic [N-1:0]           cfg_cdata,
`endif
    output logic [$clog2(N+1)-1:0] cfg_rows,
    output logic                   cfg_err
);

    localparam int              CW        = $clog2(N+1);
    localparam int              RW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   ROWS_FULL = CW'(N);

    logic [N-1:0][N-1:0] bank0;
    logic [N-1:0][N-1:0] bank1;
    logic [N-1:0][N-1:0] act_mat;
    bank_t               act;
    logic [RW-1:0]       wr_idx;
    logic                rows_full;
    logic                commit_ok;
    logic                write_ok;
    logic                err_nxt;
    logic                accept;
    logic [N-1:0]        prod;
    logic [N-1:0]        res;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign rows_full = (cfg_rows == ROWS_FULL);
    assign wr_idx    = cfg_rows[RW-1:0];
    // A successful commit needs a full shadow bank, so a write can only proceed when not full.
    assign commit_ok = cfg_commit && rows_full;
    assign write_ok  = cfg_valid && !rows_full;
    // Rejected write (bank full, including the cycle a commit empties it) or rejected commit.
    assign err_nxt   = (cfg_valid && rows_full) || (cfg_commit && !rows_full);

    // Select the bank currently serving data.
    always_comb begin
        act_mat = act ? bank1 : bank0;
    end

    gf2_matvec #(.N(N)) u_matvec (
        .mat (act_mat),
        .a   (in_data),
        .y   (prod)
    );

`ifdef GF2LM_AFFINE_EN
    logic [N-1:0] cbank0;
    logic [N-1:0] cbank1;

    // Affine constant lands in the shadow bank; it swaps along with the rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            cbank0 <= '0;
            cbank1 <= '0;
        end else if (cfg_cvalid) begin
            if (act) cbank0 <= cfg_cdata;
            else     cbank1 <= cfg_cdata;
        end
    end

    assign res = prod ^ (act ? cbank1 : cbank0);
`else
    assign res = prod;
`endif

    // Row storage: both banks reset to identity; writes only ever touch the shadow bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                bank0[i] <= N'(ident_row(i));
                bank1[i] <= N'(ident_row(i));
            end
        end else if (write_ok) begin
            if (act) bank0[wr_idx] <= cfg_data;
            else     bank1[wr_idx] <= cfg_data;
        end
    end

    // Row counter, bank select and error pulse; commit is judged on the registered count.
    always_ff @(posedge clk) begin
        if (rst) begin
            act      <= 1'b0;
            cfg_rows <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= err_nxt;
            if (commit_ok) begin
                act      <= ~act;
                cfg_rows <= '0;
            end else if (write_ok) begin
                cfg_rows <= cfg_rows + CW'(1);
            end
        end
    end

    // Output register: captures the product with the bank active at the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gf2_linmap_dbuf.sv
module tb_gf2_linmap_dbuf;

    localparam int N = 32;
`ifdef GF2LM_AFFINE_EN
    localparam bit AFF = 1'b1;
`else
    localparam bit AFF = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         cfg_valid;
    logic [N-1:0] cfg_data;
    logic         cfg_commit;
    logic         cvv;
    logic [N-1:0] cdd;
    logic [5:0]   cfg_rows;
    logic         cfg_err;

    gf2_linmap_dbuf #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
`ifdef GF2LM_AFFINE_EN
        .cfg_cvalid (cvv),
        .cfg_cdata  (cdd),
`endif
        .cfg_rows   (cfg_rows),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: matrices as plain arrays of rows plus a constant per bank.
    logic [N-1:0] sbq[$];
    logic [N-1:0] m_act[N];
    logic [N-1:0] m_shd[N];
    logic [N-1:0] m_cact;
    logic [N-1:0] m_cshd;
    int           m_rows;
    bit           m_ov;
    bit           m_err;

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act_v, exp_v, $time);
        end
    endtask

    // y[i] is the parity of the number of positions where a and row i are both set.
    function automatic logic [N-1:0] model_y(input logic [N-1:0] a);
        logic [N-1:0] y;
        for (int i = 0; i < N; i++) begin
            y[i] = ($countones(a & m_act[i]) % 2) == 1;
        end
        return y ^ m_cact;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = '0;
            m_act[i][i] = 1'b1;
            m_shd[i] = m_act[i];
        end
        m_cact = '0;
        m_cshd = '0;
        m_rows = 0;
        m_ov   = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 0; in_data = '0; out_ready = 1; cfg_valid = 0; cfg_data = '0;
        cfg_commit = 0; cvv = 0; cdd = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cfg_rows", cfg_rows, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input bit iv, input logic [N-1:0] id, input bit orr,
                        input bit cv, input logic [N-1:0] cd, input bit cc,
                        input bit ccv, input logic [N-1:0] ccd);
        bit acc;
        bit cok;
        bit wr_rej;
        logic [N-1:0] tmp[N];
        logic [N-1:0] ctmp;
        in_valid = iv; in_data = id; out_ready = orr;
        cfg_valid = cv; cfg_data = cd; cfg_commit = cc; cvv = ccv; cdd = ccd;
        #1;
        acc = iv && (!m_ov || orr);
        chk("in_ready", in_ready, (!m_ov || orr));
        if (acc) sbq.push_back(model_y(id));
        @(posedge clk);
        m_ov   = acc ? 1'b1 : (orr ? 1'b0 : m_ov);
        cok    = cc && (m_rows == N);
        wr_rej = cv && (m_rows == N || cok);
        m_err  = wr_rej || (cc && !cok);
        if (ccv && AFF) m_cshd = ccd;
        if (cok) begin
            tmp = m_act; m_act = m_shd; m_shd = tmp;
            ctmp = m_cact; m_cact = m_cshd; m_cshd = ctmp;
            m_rows = 0;
        end else if (cv && !wr_rej) begin
            m_shd[m_rows] = cd;
            m_rows++;
        end
        #1;
        chk("cfg_rows", cfg_rows, m_rows);
        chk("cfg_err", cfg_err, m_err);
        chk("out_valid", out_valid, m_ov);
    endtask

    task automatic word(input logic [N-1:0] a);
        step(1, a, 1, 0, '0, 0, 0, '0);
    endtask

    task automatic idle();
        step(0, '0, 1, 0, '0, 0, 0, '0);
    endtask

    task automatic load_row(input logic [N-1:0] r);
        step(0, '0, 1, 1, r, 0, 0, '0);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sbq.size() != 0; k++) idle();
        idle();
        chk("drain_empty", sbq.size(), 0);
    endtask

    // Monitor: compares every output transfer against the scoreboard and checks stall stability.
    initial begin
        bit held;
        logic [N-1:0] hd;
        held = 0;
        hd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
                continue;
            end
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hd);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_extra actual=%h required=none t=%0t", out_data, $time);
                end else begin
                    chk("out_data", out_data, sbq.pop_front());
                end
                held = 0;
            end else if (out_valid) begin
                held = 1;
                hd = out_data;
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        rst = 1'b1;
        do_reset();

        // Identity after reset.
        word(32'h0000_00A5);
        chk("ident_a5", out_data, 32'h0000_00A5);
        idle();

        // All-ones matrix: y is the parity of a replicated to every bit.
        for (int i = 0; i < N; i++) load_row(32'hFFFF_FFFF);
        load_row(32'h1234_5678);                      // full bank: dropped, err
        step(0, '0, 1, 0, '0, 1, 0, '0);              // commit
        word(32'h0000_0003);
        chk("ones_a3", out_data, 32'h0000_0000);
        word(32'h0000_0001);
        chk("ones_a1", out_data, 32'hFFFF_FFFF);

        // Premature commit at 31 rows is rejected and the old matrix stays live.
        for (int i = 0; i < N-1; i++) load_row($urandom);
        step(0, '0, 1, 0, '0, 1, 0, '0);
        word(32'h0000_0005);
        chk("early_commit_old", out_data, 32'h0000_0000);
        load_row($urandom);
        // Word W accepted with the commit uses the old matrix, W+1 the new one.
        step(1, 32'h0000_0001, 1, 0, '0, 1, 0, '0);
        chk("commit_same_cycle_old", out_data, 32'hFFFF_FFFF);
        word($urandom);
        idle();

        // Backpressure: three stalled cycles with a word offered each cycle.
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, '0, 0, 0, '0);
        step(1, $urandom, 1, 0, '0, 0, 0, '0);
        drain();

        // Simultaneous write + commit, both the failing and the succeeding flavour.
        for (int i = 0; i < N-1; i++) load_row($urandom);
        step(0, '0, 1, 1, $urandom, 1, 0, '0);        // commit fails, write proceeds
        step(0, '0, 1, 1, $urandom, 1, 0, '0);        // commit succeeds, write dropped
        word($urandom);

        // Randomised traffic mixing data, backpressure, row loads and commits.
        for (int c = 0; c < 500; c++) begin
            step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 15) == 0),
                 AFF && ($urandom_range(0, 7) == 0), $urandom);
        end
        drain();

`ifdef GF2LM_AFFINE_EN
        // Affine constant with identity rows: a=0 yields the constant itself.
        for (int i = 0; i < N; i++) begin
            r = '0;
            r[i] = 1'b1;
            step(0, '0, 1, 1, r, 0, (i == 0), 32'h8000_0001);
        end
        step(0, '0, 1, 0, '0, 1, 0, '0);
        word(32'h0000_0000);
        chk("affine_const", out_data, 32'h8000_0001);
        drain();
`endif

        // Reset in the middle of a row load discards the partial shadow bank.
        for (int i = 0; i < 5; i++) load_row($urandom);
        do_reset();
        r = $urandom;
        word(r);
        chk("post_reset_ident", out_data, r);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
